// File: rtl/cs3220_pkg.sv
// cs3220_pkg
// Shared definitions for the cs3220 core front end: opcode values, the
// bit positions of the instruction fields, the shadow pipeline slot
// record, and the bundle of decoded outputs held between decode and RR.
// No ports; imported with `import cs3220_pkg::*;`.
package cs3220_pkg;

    // Opcode values occupying inst[31:26]. Opcode 0 is not an instruction;
    // the all-zero word is the bubble that fetch inserts.
    localparam logic [5:0] OP_ALU_R  = 6'h01;
    localparam logic [5:0] OP_ALU_I  = 6'h02;
    localparam logic [5:0] OP_LOAD   = 6'h03;
    localparam logic [5:0] OP_STORE  = 6'h04;
    localparam logic [5:0] OP_BRANCH = 6'h05;
    localparam logic [5:0] OP_JAL    = 6'h06;

    // Instruction field positions. rs2 overlaps the top of the immediate.
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // One entry of the in-flight shadow: is there an instruction, does it
    // write the register file, and which register.
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
    } pipe_slot_t;

    // Registered decode outputs handed to the RR stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        wr_en;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        illegal;
    } dec_inst_t;

    // True for the six opcodes the core implements.
    function automatic logic op_known(input logic [5:0] op);
        return (op >= OP_ALU_R) && (op <= OP_JAL);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit
// Shadow of the in-flight pipeline (RR, EX, MEM, ...) plus the
// combinational check of the instruction in fetch against it.
// Ports:
//   clk, reset      clock and synchronous active-high reset (clears all slots)
//   flush           squash younger work: slots 0 and 1 empty, older slots age
//   advance         downstream accepted this cycle: shift slot_in into slot 0
//   slot_in         record of whatever decode issues this cycle (bubble or not)
//   rs1/rs2/rd      register specifiers of the instruction in fetch
//   *_use           which of those specifiers the instruction actually uses
//   hazard          a used specifier matches a pending register write
module hazard_unit
    import cs3220_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       advance,
    input  pipe_slot_t slot_in,
    input  logic [4:0] rs1,
    input  logic       rs1_use,
    input  logic [4:0] rs2,
    input  logic       rs2_use,
    input  logic [4:0] rd,
    input  logic       rd_use,
    output logic       hazard
);

    pipe_slot_t slots [PIPE_DEPTH];

    // Shadow shift register. On a flush the instruction in RR (slot 0)
    // is squashed, so it must not age into EX; the branch already in EX
    // and anything older keep moving so their writes are still tracked.
    // With neither flush nor advance the shadow freezes along with RR.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            slots[0] <= '0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                if (i == 1) begin
                    slots[i] <= '0;
                end else begin
                    slots[i] <= slots[i-1];
                end
            end
        end else if (advance) begin
            slots[0] <= slot_in;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    // Without forwarding, any pending write to a register the fetch
    // instruction reads or writes blocks it. r0 is excluded upstream: the
    // use flags are never set for r0 and slots never record a write to r0.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (slots[i].valid && slots[i].wr) begin
                if ((rs1_use && (rs1 == slots[i].rd)) ||
                    (rs2_use && (rs2 == slots[i].rd)) ||
                    (rd_use  && (rd  == slots[i].rd))) begin
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Decode stage of the cs3220 core. Splits the fetch instruction into
// fields, checks it against the in-flight shadow, and issues either the
// decoded instruction or a bubble into RR.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   fetch_pc/inst    instruction held by fetch (32'h0 is a bubble)
//   exec_ld_pc       EX redirect; squash everything younger than EX
//   rr_stall         RR cannot accept this cycle
//   decode_stall     fetch must hold its instruction
//   decode_flush     fetch must drop its instruction
//   dec_*            registered decoded instruction for RR
module decode_stage
    import cs3220_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_inst,
    input  logic        exec_ld_pc,
    input  logic        rr_stall,
    output logic        decode_stall,
    output logic        decode_flush,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [5:0]  dec_op,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [31:0] dec_imm,
    output logic        dec_wr_en,
    output logic        dec_is_load,
    output logic        dec_is_store,
    output logic        dec_is_branch,
    output logic        dec_illegal
);

    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        known;
    logic        illegal;
    logic        writes_rd;
    logic        reads_rs2;
    logic        wr_en;
    logic        rs1_use;
    logic        rs2_use;
    logic        hazard;
    logic        issue;
    pipe_slot_t  slot_in;
    dec_inst_t   dec_next;
    dec_inst_t   dec_q;

    assign op  = fetch_inst[OP_MSB:OP_LSB];
    assign rd  = fetch_inst[RD_MSB:RD_LSB];
    assign rs1 = fetch_inst[RS1_MSB:RS1_LSB];
    assign rs2 = fetch_inst[RS2_MSB:RS2_LSB];
    assign imm = {{16{fetch_inst[IMM_MSB]}}, fetch_inst[IMM_MSB:IMM_LSB]};

    // Opcode classification. Every known opcode reads rs1; the table only
    // has to say who writes rd and who also reads rs2. A zero opcode is a
    // bubble rather than an illegal instruction, so it sets no use flags.
    always_comb begin
        known     = op_known(op);
        illegal   = (op != 6'h00) && !known;
        writes_rd = 1'b0;
        reads_rs2 = 1'b0;
        case (op)
            OP_ALU_R: begin
                writes_rd = 1'b1;
                reads_rs2 = 1'b1;
            end
            OP_ALU_I, OP_LOAD, OP_JAL: begin
                writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                reads_rs2 = 1'b1;
            end
            default: begin
            end
        endcase
        wr_en   = writes_rd && (rd != 5'd0);
        rs1_use = known && (rs1 != 5'd0);
        rs2_use = reads_rs2 && (rs2 != 5'd0);
    end

    // Fetch controls come only from inputs and the registered shadow, so
    // no path loops back through fetch. A flush overrides any stall.
    assign decode_flush = exec_ld_pc | i_reset;
    assign decode_stall = (hazard | rr_stall) & ~decode_flush;
    assign issue        = known & ~hazard;

    // What enters shadow slot 0 if RR accepts: the issued instruction's
    // write, or an empty slot for a bubble, hazard or illegal opcode.
    always_comb begin
        slot_in       = '0;
        slot_in.valid = issue;
        slot_in.wr    = issue && wr_en;
        slot_in.rd    = rd;
    end

    hazard_unit #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_hazard (
        .clk     (i_clk),
        .reset   (i_reset),
        .flush   (exec_ld_pc),
        .advance (~rr_stall),
        .slot_in (slot_in),
        .rs1     (rs1),
        .rs1_use (rs1_use),
        .rs2     (rs2),
        .rs2_use (rs2_use),
        .rd      (rd),
        .rd_use  (wr_en),
        .hazard  (hazard)
    );

    // Next decode bundle. Bubbles of any kind are all-zero; an illegal
    // opcode additionally raises dec_illegal so RR can see why.
    always_comb begin
        dec_next = '0;
        if (issue) begin
            dec_next.valid     = 1'b1;
            dec_next.pc        = fetch_pc;
            dec_next.op        = op;
            dec_next.rd        = rd;
            dec_next.rs1       = rs1;
            dec_next.rs2       = rs2;
            dec_next.imm       = imm;
            dec_next.wr_en     = wr_en;
            dec_next.is_load   = (op == OP_LOAD);
            dec_next.is_store  = (op == OP_STORE);
            dec_next.is_branch = (op == OP_BRANCH);
        end else if (illegal) begin
            dec_next.illegal = 1'b1;
        end
    end

    // Output register: reset/flush empty RR, an RR stall holds it,
    // otherwise it takes whatever decode produced this cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || exec_ld_pc) begin
            dec_q <= '0;
        end else if (!rr_stall) begin
            dec_q <= dec_next;
        end
    end

    assign dec_valid     = dec_q.valid;
    assign dec_pc        = dec_q.pc;
    assign dec_op        = dec_q.op;
    assign dec_rd        = dec_q.rd;
    assign dec_rs1       = dec_q.rs1;
    assign dec_rs2       = dec_q.rs2;
    assign dec_imm       = dec_q.imm;
    assign dec_wr_en     = dec_q.wr_en;
    assign dec_is_load   = dec_q.is_load;
    assign dec_is_store  = dec_q.is_store;
    assign dec_is_branch = dec_q.is_branch;
    assign dec_illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Drives decode_stage as fetch would and compares it each cycle against a
// reference model that tracks in-flight register writes as a plain list.
module tb_decode_stage;

    localparam int D = 3;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        exec_ld_pc;
    logic        rr_stall;
    logic        decode_stall;
    logic        decode_flush;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [31:0] dec_imm;
    logic        dec_wr_en;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_is_branch;
    logic        dec_illegal;

    decode_stage #(.PIPE_DEPTH(D)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .fetch_pc      (fetch_pc),
        .fetch_inst    (fetch_inst),
        .exec_ld_pc    (exec_ld_pc),
        .rr_stall      (rr_stall),
        .decode_stall  (decode_stall),
        .decode_flush  (decode_flush),
        .dec_valid     (dec_valid),
        .dec_pc        (dec_pc),
        .dec_op        (dec_op),
        .dec_rd        (dec_rd),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_imm       (dec_imm),
        .dec_wr_en     (dec_wr_en),
        .dec_is_load   (dec_is_load),
        .dec_is_store  (dec_is_store),
        .dec_is_branch (dec_is_branch),
        .dec_illegal   (dec_illegal)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference state: registers with a pending write, youngest first
    // (-1 = nothing pending at that age), and the expected RR contents.
    int          pend [D];
    logic        eValid;
    logic        eIll;
    logic        eDefined;
    logic [31:0] ePc;
    logic [31:0] eImm;
    logic [24:0] eFields;
    logic        lastExpStall;
    logic        lastDutStall;
    int          dutStalls;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic bit opKnown(input logic [5:0] op);
        return (op >= 6'd1) && (op <= 6'd6);
    endfunction

    function automatic bit opWrites(input logic [5:0] op);
        return (op == 6'd1) || (op == 6'd2) || (op == 6'd3) || (op == 6'd6);
    endfunction

    function automatic bit opReadsRs2(input logic [5:0] op);
        return (op == 6'd1) || (op == 6'd4) || (op == 6'd5);
    endfunction

    function automatic bit pending(input logic [4:0] r);
        for (int i = 0; i < D; i++) begin
            if (pend[i] == int'(r)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit modelHazard(input logic [31:0] inst);
        logic [5:0] op;
        logic [4:0] rd, rs1, rs2;
        op  = inst[31:26];
        rd  = inst[25:21];
        rs1 = inst[20:16];
        rs2 = inst[15:11];
        if (!opKnown(op)) return 1'b0;
        return (rs1 != 0 && pending(rs1)) ||
               (opReadsRs2(op) && rs2 != 0 && pending(rs2)) ||
               (opWrites(op) && rd != 0 && pending(rd));
    endfunction

    task automatic modelClear(input logic fieldsKnown);
        eValid   = 1'b0;
        eIll     = 1'b0;
        ePc      = '0;
        eImm     = '0;
        eFields  = '0;
        eDefined = fieldsKnown;
    endtask

    task automatic modelUpdate(input logic [31:0] inst, input logic [31:0] pc,
                               input logic ld, input logic rr, input logic rst, input logic haz);
        logic [5:0] op;
        logic [4:0] rd;
        bit         iss;
        op = inst[31:26];
        rd = inst[25:21];
        if (rst) begin
            for (int i = 0; i < D; i++) pend[i] = -1;
            modelClear(1'b1);
        end else if (ld) begin
            for (int i = D - 1; i >= 2; i--) pend[i] = pend[i-1];
            pend[1] = -1;
            pend[0] = -1;
            modelClear(1'b0);
        end else if (!rr) begin
            iss = opKnown(op) && !haz;
            for (int i = D - 1; i >= 1; i--) pend[i] = pend[i-1];
            pend[0] = (iss && opWrites(op) && rd != 0) ? int'(rd) : -1;
            if (iss) begin
                eValid   = 1'b1;
                eIll     = 1'b0;
                ePc      = pc;
                eImm     = {{16{inst[15]}}, inst[15:0]};
                eFields  = {op, rd, inst[20:16], inst[15:11],
                            logic'(opWrites(op) && rd != 0), logic'(op == 6'd3),
                            logic'(op == 6'd4), logic'(op == 6'd5)};
                eDefined = 1'b1;
            end else begin
                eValid   = 1'b0;
                eIll     = (op != 0) && !opKnown(op);
                eDefined = 1'b0;
            end
        end
    endtask

    // One fetch cycle: apply inputs, check the combinational controls,
    // take the clock edge, then check what RR received.
    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic ld, input logic rr, input logic rst);
        logic expFlush, expHaz, expStall;
        fetch_inst = inst;
        fetch_pc   = pc;
        exec_ld_pc = ld;
        rr_stall   = rr;
        i_reset    = rst;
        #3;
        expFlush = ld | rst;
        expHaz   = modelHazard(inst);
        expStall = (expHaz | rr) & ~expFlush;
        checkOutput("decode_flush", decode_flush, expFlush);
        checkOutput("decode_stall", decode_stall, expStall);
        lastExpStall = expStall;
        lastDutStall = decode_stall;
        @(posedge i_clk);
        modelUpdate(inst, pc, ld, rr, rst, expHaz);
        #1;
        checkOutput("dec_valid", dec_valid, eValid);
        checkOutput("dec_illegal", dec_illegal, eIll);
        if (eDefined) begin
            checkOutput("dec_pc", dec_pc, ePc);
            checkOutput("dec_imm", dec_imm, eImm);
            checkOutput("dec_fields",
                        {dec_op, dec_rd, dec_rs1, dec_rs2,
                         dec_wr_en, dec_is_load, dec_is_store, dec_is_branch},
                        eFields);
        end
    endtask

    // Present an instruction until it is accepted, counting the cycles
    // in which the DUT asked fetch to hold.
    task automatic runInst(input logic [31:0] inst, input logic [31:0] pc);
        int n;
        n = 0;
        dutStalls = 0;
        applyStimulus(inst, pc, 1'b0, 1'b0, 1'b0);
        if (lastDutStall) dutStalls++;
        while (lastExpStall && n < 16) begin
            n++;
            applyStimulus(inst, pc, 1'b0, 1'b0, 1'b0);
            if (lastDutStall) dutStalls++;
        end
    endtask

    function automatic logic [31:0] randInst();
        int         sel;
        logic [5:0] op;
        logic [4:0] rs2;
        sel = $urandom_range(0, 15);
        if (sel < 2) return 32'h0;
        op  = (sel == 2) ? 6'($urandom_range(7, 63)) : 6'($urandom_range(1, 6));
        rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), rs2, 11'($urandom)};
    endfunction

    initial begin
        logic [31:0] cur;
        logic [31:0] curPc;
        logic        rst, ld, rr;

        for (int i = 0; i < D; i++) pend[i] = -1;
        modelClear(1'b1);
        lastExpStall = 1'b0;
        lastDutStall = 1'b0;
        i_reset    = 1'b1;
        fetch_pc   = '0;
        fetch_inst = '0;
        exec_ld_pc = 1'b0;
        rr_stall   = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset: every output must be zero afterwards.
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Independent ALU_I pair, no stalls.
        runInst(mk(6'd2, 5'd1, 5'd0, 16'd5), 32'h100);
        checkOutput("indep1_stalls", dutStalls, 0);
        checkOutput("indep1_imm", dec_imm, 32'd5);
        runInst(mk(6'd2, 5'd2, 5'd0, 16'd7), 32'h104);
        checkOutput("indep2_stalls", dutStalls, 0);
        checkOutput("indep2_imm", dec_imm, 32'd7);

        // RAW: r4 = r3 + r3 waits for r3's writer to leave the shadow.
        runInst(mk(6'd2, 5'd3, 5'd0, 16'd1), 32'h108);
        runInst(mk(6'd1, 5'd4, 5'd3, {5'd3, 11'd0}), 32'h10C);
        checkOutput("raw_stalls", dutStalls, D);
        checkOutput("raw_issue_pc", dec_pc, 32'h10C);

        // r0 destination and an r0 reader.
        runInst(mk(6'd2, 5'd0, 5'd0, 16'd9), 32'h110);
        checkOutput("r0_wr_en", dec_wr_en, 0);
        runInst(mk(6'd1, 5'd6, 5'd0, 16'd0), 32'h114);
        checkOutput("r0_reader_stalls", dutStalls, 0);

        // Flush while r5's writer sits in RR and its reader is in fetch.
        runInst(mk(6'd2, 5'd5, 5'd0, 16'd3), 32'h118);
        applyStimulus(mk(6'd2, 5'd7, 5'd5, 16'd1), 32'h11C, 1'b1, 1'b0, 1'b0);
        runInst(mk(6'd2, 5'd8, 5'd5, 16'd2), 32'h200);
        checkOutput("flush_reader_stalls", dutStalls, 0);

        // Downstream stall for two cycles, then the full hazard wait.
        runInst(mk(6'd2, 5'd9, 5'd0, 16'hFFF0), 32'h204);
        checkOutput("neg_imm", dec_imm, 32'hFFFF_FFF0);
        applyStimulus(mk(6'd1, 5'd10, 5'd9, {5'd9, 11'd0}), 32'h208, 1'b0, 1'b1, 1'b0);
        applyStimulus(mk(6'd1, 5'd10, 5'd9, {5'd9, 11'd0}), 32'h208, 1'b0, 1'b1, 1'b0);
        checkOutput("rr_hold_pc", dec_pc, 32'h204);
        runInst(mk(6'd1, 5'd10, 5'd9, {5'd9, 11'd0}), 32'h208);
        checkOutput("rr_then_hazard_stalls", dutStalls, D);

        // Illegal opcode goes out as a flagged bubble.
        runInst({6'h3F, 26'h1234567}, 32'h20C);
        checkOutput("illegal_flag", dec_illegal, 1);
        checkOutput("illegal_valid", dec_valid, 0);

        // Reset in the middle of a hazard stall.
        runInst(mk(6'd2, 5'd11, 5'd0, 16'd1), 32'h210);
        applyStimulus(mk(6'd2, 5'd12, 5'd11, 16'd1), 32'h214, 1'b0, 1'b0, 1'b0);
        applyStimulus(mk(6'd2, 5'd12, 5'd11, 16'd1), 32'h214, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_mid_bundle", {dec_valid, dec_pc, dec_imm[15:0], dec_wr_en}, 0);
        runInst(mk(6'd2, 5'd12, 5'd11, 16'd1), 32'h214);
        checkOutput("post_reset_stalls", dutStalls, 0);
        checkOutput("post_reset_valid", dec_valid, 1);

        // Randomized traffic with downstream stalls, redirects and resets.
        cur   = randInst();
        curPc = 32'h1000;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 19) == 0);
            rr  = ($urandom_range(0, 4) == 0);
            applyStimulus(cur, curPc, ld, rr, rst);
            if (!lastExpStall) begin
                cur   = randInst();
                curPc = curPc + 32'd4;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the cs3220 core pipeline, directly downstream of fetch. It takes the instruction register produced by fetch, decodes it into register and immediate fields, and detects read-after-write and write-after-write hazards using a shadow of the in-flight pipeline. It issues decoded instructions, or bubbles, into the register-read (RR) stage. It produces the `decode_stall` and `decode_flush` controls that fetch consumes.

## Interface
- `PIPE_DEPTH`, default 3: number of tracked in-flight slots (RR, EX, MEM). An instruction leaving the last slot has written the register file.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset (one clock; reset synchronous and active-high).
- `fetch_pc`  in  32  PC of the instruction held by fetch.
- `fetch_inst`  in  32  instruction held by fetch; 32'h0 is a bubble.
- `exec_ld_pc`  in  1  EX has a taken or mispredicted branch; squash younger instructions.
- `rr_stall`  in  1  RR cannot accept this cycle.
- `decode_stall`  out  1  fetch must hold (combinational).
- `decode_flush`  out  1  fetch must discard its instruction (combinational).
- `dec_valid`  out  1  `dec_*` holds a real instruction.
- `dec_pc`  out  32  PC of the decoded instruction.
- `dec_op`  out  6  opcode.
- `dec_rd`, `dec_rs1`, `dec_rs2`  out  5 each  register specifiers.
- `dec_imm`  out  32  `inst[15:0]`, sign-extended.
- `dec_wr_en`, `dec_is_load`, `dec_is_store`, `dec_is_branch`  out  1 each  class flags.
- `dec_illegal`  out  1  unknown nonzero opcode; this instruction is issued as a bubble.

## Operation
- Field layout: op = `inst[31:26]`, rd = `[25:21]`, rs1 = `[20:16]`, rs2 = `[15:11]`, imm = `[15:0]`.
- Opcode classes:
  - 01 ALU_R: writes rd; reads rs1 and rs2.
  - 02 ALU_I: writes rd; reads rs1.
  - 03 LOAD: writes rd; reads rs1.
  - 04 STORE: reads rs1 and rs2.
  - 05 BRANCH: reads rs1 and rs2.
  - 06 JAL: writes rd; reads rs1.
- Write suppression: `dec_wr_en` is 0 when rd == 0. r0 never causes a hazard, as either source or destination.
- Shadow: `PIPE_DEPTH` entries of {valid, wr, rd}. Slot 0 mirrors the `dec_*` register (the instruction in RR).
- Hazard: asserted when the fetch instruction is real, and either one of its used sources, or its written rd, matches the rd of a valid writing shadow slot. There is no forwarding.
- `decode_flush` = `exec_ld_pc | i_reset`.
- `decode_stall` = (hazard | `rr_stall`) & !`decode_flush`.
- Output register update, in priority order:
  1. Reset or flush: `dec_valid` <= 0; shadow slot 0 is invalidated. The branch in slot 1 and older slots still advance normally.
  2. Else if `rr_stall`: `dec_*` and all shadow slots hold.
  3. Else if hazard, bubble, or illegal: a bubble enters slot 0 and the other slots shift.
  4. Else: the decoded instruction is issued into slot 0 and the other slots shift.
- Every cycle without `rr_stall`: slot[i+1] <= slot[i]; the last slot drops off.

## Timing
- Reset values: every shadow valid bit is 0. All `dec_*` outputs are 0, including `dec_valid`, `dec_pc`, `dec_imm`, and `dec_illegal`.
- Latency: a fetched instruction appears on `dec_*` one cycle after it is accepted, meaning a cycle in which `decode_stall` = 0.
- A dependent back-to-back pair stalls `PIPE_DEPTH` cycles. The consumer issues once the producer has left the last slot.
- Simultaneous events:
  - `exec_ld_pc` with `rr_stall`: the flush wins; slot 0 is cleared.
  - `exec_ld_pc` with a hazard: the flush wins, and `decode_stall` = 0.
- Reset mid-stall clears everything. The next instruction issues with no hazard.
- `decode_stall` and `decode_flush` depend only on current inputs and registered state. There are no combinational loops through fetch.

## Structure
- `cs3220_pkg` holds:
  - opcode localparams `OP_ALU_R` .. `OP_JAL`;
  - field-position constants;
  - a `pipe_slot_t` struct {valid, wr, rd[4:0]};
  - a `dec_inst_t` struct for the `dec_*` bundle.
- One sub-module, `hazard_unit`: holds the shadow shift register and a combinational match. Inputs are the sources, rd, and their use flags; the output is the hazard flag. The advance and flush controls are driven by `decode_stage`.

## Test plan
- **Independent instructions:** ALU_I r1 ← r0+5, then ALU_I r2 ← r0+7, no stalls. Required: each appears on `dec_*` one cycle after it is accepted, with `dec_imm` = 5 and 7, and `decode_stall` never asserts.
- **RAW stall:** ALU_I r3 followed by ALU_R r4 = r3+r3. Required: `decode_stall` is high for exactly 3 cycles, during which `dec_valid` = 0; then r4's instruction issues.
- **r0 destination:** ALU_I with rd = 0, followed by a reader of r0. Required: no stall, and `dec_wr_en` = 0.
- **Flush:**
  - Stimulus: `exec_ld_pc` pulses while r5's writer sits in slot 0 and a reader of r5 is in fetch.
  - Required: `decode_flush` = 1 and `decode_stall` = 0 that cycle; `dec_valid` = 0 next cycle.
  - Then a new reader of r5 issues with no stall.
- **Downstream stall:** `rr_stall` held 2 cycles. Required: `decode_stall` = 1 and `dec_*` stays unchanged; there is no shadow aging, so a pending hazard still stalls the full 3 cycles afterwards.
- **Illegal opcode and reset:**
  - Opcode 6'h3F: required `dec_illegal` = 1 with `dec_valid` = 0.
  - Reset mid-stall: required all outputs 0, then a clean issue on the next instruction.
